fsm_add_subt_ctrl: RTL and testbench
====================================

# fsm_add_subt_ctrl

Sequencing controller for the floating-point add/subtract unit. It drives the load enables of the operand front-end (operand/opcode registers, then magnitude-sorted DMP/DmP registers) and every later datapath stage: exponent difference, alignment shifting, add, overflow correction, normalization, rounding and result load. The controller holds bounded shift counters and a start/ready/ack handshake toward the FPU top level.

## Interface
- W, 32: IEEE-754 word width (32 single, 64 double); informational, passed down with the datapath.
- EW, 8: exponent width; width of `exp_diff_i`.
- SW, 26: maximum alignment and normalization shift count (significand plus guard bits).
- CW, 5: shift counter width; must satisfy 2^CW > SW.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising edge of clk.
- beg_fsm_i  in  1  start request; sampled only in IDLE.
- ack_fsm_i  in  1  result consumed; sampled only in READY.
- zero_flag_i  in  1  effective subtract of equal magnitudes, from front-end.
- exp_diff_i  in  EW  unsigned exponent difference (DMP minus DmP), valid in EXP_CALC.
- carry_i  in  1  adder carry-out, valid in CARRY_CHK.
- msb_i  in  1  leading bit of the sum register, valid in NORM.
- ctrl_a_o  out  1  load operand and opcode registers.
- ctrl_b_o  out  1  load DMP/DmP registers.
- load_exp_o  out  1  load exponent-difference register.
- shift_en_o  out  1  one-bit right shift of DmP significand.
- add_en_o  out  1  capture adder result.
- ovf_shift_o  out  1  one-bit right shift and exponent increment on carry.
- norm_shift_o  out  1  one-bit left shift and exponent decrement.
- round_o  out  1  apply rounding.
- load_result_o  out  1  load output register.
- zero_res_o  out  1  force a +0 result (bypass only).
- busy_o  out  1  high in every state except IDLE.
- ready_o  out  1  result valid; high in READY.

## Operation
- States: IDLE, LOAD_OP, CLASSIFY, EXP_CALC, ALIGN, ADD, CARRY_CHK, NORM, ROUND, LOAD_RES, READY. Moore outputs, except `norm_shift_o` and `ovf_shift_o`.
- IDLE: if beg_fsm_i, go to LOAD_OP. Otherwise stay.
- LOAD_OP: ctrl_a_o=1, then go to CLASSIFY.
- CLASSIFY: ctrl_b_o=1, then go to EXP_CALC (see Configuration).
- EXP_CALC: load_exp_o=1. Load align_cnt = min(exp_diff_i, SW), saturating. If the loaded value is 0, go to ADD; otherwise go to ALIGN.
- ALIGN: shift_en_o=1 and align_cnt decrements by 1 each cycle. Exit to ADD in the cycle where align_cnt==1, so there are exactly D cycles, where D = min(exp_diff_i, SW).
- ADD: add_en_o=1, then go to CARRY_CHK.
- CARRY_CHK: ovf_shift_o=carry_i. If carry_i, go to ROUND. Otherwise clear norm_cnt and go to NORM.
- NORM: norm_shift_o = !msb_i && norm_cnt<SW, and norm_cnt increments when shifting. Exit to ROUND when msb_i or norm_cnt==SW. N shifts take N+1 cycles, with N ≤ SW.
- ROUND: round_o=1, then go to LOAD_RES.
- LOAD_RES: load_result_o=1, then go to READY.
- READY: ready_o=1, held until ack_fsm_i, then go to IDLE.
- beg_fsm_i outside IDLE and ack_fsm_i outside READY are ignored. No queuing.
- If beg_fsm_i and ack_fsm_i are both high in READY, only the ack takes effect. The new start is sampled in IDLE at the earliest one cycle later.
- rst low at any edge, including mid-ALIGN or mid-NORM:
  - state goes to IDLE;
  - both counters clear to 0;
  - every output is 0 in the following cycle.

## Timing
- Reset value of every output: 0. busy_o=0 and ready_o=0.
- Each control output is a single-cycle pulse per state visit, except shift_en_o (D cycles) and norm_shift_o (N cycles).
- Latency, counted from the edge that samples beg_fsm_i to the first cycle with ready_o=1:
  - carry path: 8+D cycles;
  - no-carry path: 9+D+N cycles;
  - zero bypass: 4 cycles.
- Throughput: one operation per latency+1 cycles, with minimum ack.

## Configuration
- Macro: ZERO_BYPASS_EN.
- Defined: in CLASSIFY, if zero_flag_i=1, the next state is LOAD_RES with zero_res_o=1 and load_result_o=1. ALIGN through ROUND are skipped.
- Undefined: zero_flag_i is ignored and zero_res_o is tied to 0. An equal-magnitude subtract runs the full path, and NORM terminates on norm_cnt==SW (N=SW).

## Test plan
- Reset with rst=0 for 2 cycles while busy_o=1 in ALIGN (exp_diff_i=10) -> IDLE next cycle, all outputs 0, align_cnt=0; a later beg_fsm_i starts cleanly.
- beg_fsm_i=1 for 1 cycle, exp_diff_i=3, carry_i=1 -> shift_en_o high 3 cycles, ovf_shift_o pulse, ready_o high 11 cycles after start, held until ack_fsm_i.
- exp_diff_i=40 -> exactly 26 shift_en_o cycles (saturation).
- exp_diff_i=0, carry_i=0, msb_i rising after 5 norm shifts -> norm_shift_o high 5 cycles, NORM 6 cycles, ready_o at cycle 14.
- zero_flag_i=1 with ZERO_BYPASS_EN -> zero_res_o and load_result_o in cycle 3, ready_o cycle 4. Without the macro -> 26 norm_shift_o cycles.
- beg_fsm_i held high throughout and ack_fsm_i pulsed early in ADD -> both ignored; second operation starts only after the ack in READY and the return to IDLE.

Source files
------------

// File: rtl/fsm_add_subt_ctrl.sv
// Sequencing controller for the floating-point add/subtract datapath.
// Optional macro ZERO_BYPASS_EN: equal-magnitude subtracts skip to a +0 result.
//
// Ports:
//   clk, rst (sync, active-low)
//   beg_fsm_i / ack_fsm_i     : start request / result consumed
//   zero_flag_i               : equal-magnitude effective subtract
//   exp_diff_i [EW-1:0]       : unsigned exponent difference
//   carry_i, msb_i            : adder carry-out, sum leading bit
//   ctrl_a_o .. load_result_o : datapath stage enables
//   zero_res_o                : force +0 result (bypass build only)
//   busy_o, ready_o           : status toward the FPU top level
module fsm_add_subt_ctrl #(
    parameter int W  = 32,
    parameter int EW = 8,
    parameter int SW = 26,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beg_fsm_i,
    input  logic          ack_fsm_i,
    input  logic          zero_flag_i,
    input  logic [EW-1:0] exp_diff_i,
    input  logic          carry_i,
    input  logic          msb_i,
    output logic          ctrl_a_o,
    output logic          ctrl_b_o,
    output logic          load_exp_o,
    output logic          shift_en_o,
    output logic          add_en_o,
    output logic          ovf_shift_o,
    output logic          norm_shift_o,
    output logic          round_o,
    output logic          load_result_o,
    output logic          zero_res_o,
    output logic          busy_o,
    output logic          ready_o
);

    // Elaboration-time sanity on the configuration.
    if ((1 << CW) <= SW) begin : g_bad_cw
        $error("CW too narrow to count to SW");
    end
    if (W != 32 && W != 64) begin : g_bad_w
        $error("W must be 32 or 64");
    end

    typedef enum logic [3:0] {
        IDLE,
        LOAD_OP,
        CLASSIFY,
        EXP_CALC,
        ALIGN,
        ADD,
        CARRY_CHK,
        NORM,
        ROUND,
        LOAD_RES,
        READY
    } state_t;

    localparam logic [CW-1:0] SW_C = CW'(SW);

    state_t        state_q, state_d;
    logic [CW-1:0] align_cnt_q, align_cnt_d;
    logic [CW-1:0] norm_cnt_q, norm_cnt_d;
    logic [CW-1:0] align_load;

`ifdef ZERO_BYPASS_EN
    // Remembers that this operation took the bypass, so LOAD_RES
    // can drive zero_res_o as a plain state output.
    logic zero_q, zero_d;
`else
    logic unused_zero_flag;
    assign unused_zero_flag = zero_flag_i;
`endif

    // Saturate the alignment distance; shifting further than the
    // significand width only moves zeros into sticky positions.
    always_comb begin
        if (32'(exp_diff_i) >= 32'(SW)) begin
            align_load = SW_C;
        end else begin
            align_load = CW'(exp_diff_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            align_cnt_q <= '0;
            norm_cnt_q  <= '0;
`ifdef ZERO_BYPASS_EN
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            align_cnt_q <= align_cnt_d;
            norm_cnt_q  <= norm_cnt_d;
`ifdef ZERO_BYPASS_EN
            zero_q      <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        align_cnt_d   = align_cnt_q;
        norm_cnt_d    = norm_cnt_q;
        ctrl_a_o      = 1'b0;
        ctrl_b_o      = 1'b0;
        load_exp_o    = 1'b0;
        shift_en_o    = 1'b0;
        add_en_o      = 1'b0;
        ovf_shift_o   = 1'b0;
        norm_shift_o  = 1'b0;
        round_o       = 1'b0;
        load_result_o = 1'b0;
        zero_res_o    = 1'b0;
        busy_o        = (state_q != IDLE);
        ready_o       = 1'b0;
`ifdef ZERO_BYPASS_EN
        zero_d        = zero_q;
`endif

        unique case (state_q)
            IDLE: begin
`ifdef ZERO_BYPASS_EN
                zero_d = 1'b0;
`endif
                if (beg_fsm_i) begin
                    state_d = LOAD_OP;
                end
            end
            LOAD_OP: begin
                ctrl_a_o = 1'b1;
                state_d  = CLASSIFY;
            end
            CLASSIFY: begin
                ctrl_b_o = 1'b1;
                state_d  = EXP_CALC;
`ifdef ZERO_BYPASS_EN
                if (zero_flag_i) begin
                    zero_d  = 1'b1;
                    state_d = LOAD_RES;
                end
`endif
            end
            EXP_CALC: begin
                load_exp_o  = 1'b1;
                align_cnt_d = align_load;
                if (align_load == '0) begin
                    state_d = ADD;
                end else begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                shift_en_o  = 1'b1;
                align_cnt_d = align_cnt_q - 1'b1;
                // Leave on the last shift; <= also recovers from a stray 0.
                if (align_cnt_q <= CW'(1)) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                add_en_o = 1'b1;
                state_d  = CARRY_CHK;
            end
            CARRY_CHK: begin
                ovf_shift_o = carry_i;
                if (carry_i) begin
                    state_d = ROUND;
                end else begin
                    norm_cnt_d = '0;
                    state_d    = NORM;
                end
            end
            NORM: begin
                if (!msb_i && norm_cnt_q < SW_C) begin
                    norm_shift_o = 1'b1;
                    norm_cnt_d   = norm_cnt_q + 1'b1;
                end
                if (msb_i || norm_cnt_q == SW_C) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                round_o = 1'b1;
                state_d = LOAD_RES;
            end
            LOAD_RES: begin
                load_result_o = 1'b1;
`ifdef ZERO_BYPASS_EN
                zero_res_o    = zero_q;
`endif
                state_d       = READY;
            end
            READY: begin
                ready_o = 1'b1;
                if (ack_fsm_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fsm_add_subt_ctrl.sv
// Directed self-checking bench for fsm_add_subt_ctrl.
// Latencies are counted from the edge sampling beg_fsm_i (cycle 1 = LOAD_OP).
module tb_fsm_add_subt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       beg_fsm_i = 1'b0;
    logic       ack_fsm_i = 1'b0;
    logic       zero_flag_i = 1'b0;
    logic [7:0] exp_diff_i = '0;
    logic       carry_i = 1'b0;
    logic       msb_i = 1'b0;
    logic       ctrl_a_o, ctrl_b_o, load_exp_o, shift_en_o;
    logic       add_en_o, ovf_shift_o, norm_shift_o, round_o;
    logic       load_result_o, zero_res_o, busy_o, ready_o;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fsm_add_subt_ctrl #(.W(32), .EW(8), .SW(26), .CW(5)) dut (
        .clk(clk), .rst(rst),
        .beg_fsm_i(beg_fsm_i), .ack_fsm_i(ack_fsm_i),
        .zero_flag_i(zero_flag_i), .exp_diff_i(exp_diff_i),
        .carry_i(carry_i), .msb_i(msb_i),
        .ctrl_a_o(ctrl_a_o), .ctrl_b_o(ctrl_b_o),
        .load_exp_o(load_exp_o), .shift_en_o(shift_en_o),
        .add_en_o(add_en_o), .ovf_shift_o(ovf_shift_o),
        .norm_shift_o(norm_shift_o), .round_o(round_o),
        .load_result_o(load_result_o), .zero_res_o(zero_res_o),
        .busy_o(busy_o), .ready_o(ready_o)
    );

    wire [11:0] outs = {ctrl_a_o, ctrl_b_o, load_exp_o, shift_en_o,
                        add_en_o, ovf_shift_o, norm_shift_o, round_o,
                        load_result_o, zero_res_o, busy_o, ready_o};

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from start until ready_o, counting pulses.
    // msb_i rises once n_tgt normalization shifts have been seen.
    task automatic run_op(input int n_tgt, output int lat, output int sh,
                          output int ns, output int ov, output int zr,
                          output int zr_cyc);
        int cyc;
        lat = -1; sh = 0; ns = 0; ov = 0; zr = 0; zr_cyc = -1;
        beg_fsm_i = 1'b1;
        tick();
        beg_fsm_i = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            msb_i = (ns >= n_tgt);
            #1;
            if (shift_en_o) sh++;
            if (norm_shift_o) ns++;
            if (ovf_shift_o) ov++;
            if (zero_res_o) begin
                zr++;
                zr_cyc = cyc;
            end
            if (ready_o) begin
                lat = cyc;
                break;
            end
            tick();
            cyc++;
        end
        msb_i = 1'b0;
    endtask

    task automatic do_ack(input string tag);
        ack_fsm_i = 1'b1;
        tick();
        ack_fsm_i = 1'b0;
        chk({tag, "_idle_outs"}, int'(outs), 0);
    endtask

    initial begin
        int lat, sh, ns, ov, zr, zc, cyc;

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        chk("reset_outs", int'(outs), 0);
        rst = 1'b1;
        tick();
        chk("idle_outs", int'(outs), 0);

        // Reset in the middle of ALIGN (exp_diff 10)
        exp_diff_i = 8'd10;
        carry_i = 1'b1;
        beg_fsm_i = 1'b1;
        tick();
        beg_fsm_i = 1'b0;
        chk("mid_ctrl_a", int'(ctrl_a_o), 1);
        tick(); tick(); tick(); tick();
        chk("mid_align_shift", int'(shift_en_o), 1);
        chk("mid_align_busy", int'(busy_o), 1);
        rst = 1'b0;
        tick();
        chk("rst_mid_outs1", int'(outs), 0);
        tick();
        chk("rst_mid_outs2", int'(outs), 0);
        rst = 1'b1;
        tick();
        chk("rst_mid_idle", int'(outs), 0);

        // Clean restart after reset: D=2, carry
        exp_diff_i = 8'd2;
        run_op(0, lat, sh, ns, ov, zr, zc);
        chk("after_rst_lat", lat, 10);
        chk("after_rst_shifts", sh, 2);
        do_ack("after_rst");

        // D=3 carry path: ready after 11, held until ack
        exp_diff_i = 8'd3;
        carry_i = 1'b1;
        run_op(0, lat, sh, ns, ov, zr, zc);
        chk("d3_lat", lat, 11);
        chk("d3_shifts", sh, 3);
        chk("d3_ovf", ov, 1);
        chk("d3_norm", ns, 0);
        tick(); tick(); tick();
        chk("d3_ready_hold", int'(ready_o), 1);
        chk("d3_busy_hold", int'(busy_o), 1);
        do_ack("d3");

        // Saturation: exp_diff 40 -> 26 shifts
        exp_diff_i = 8'd40;
        run_op(0, lat, sh, ns, ov, zr, zc);
        chk("sat_shifts", sh, 26);
        chk("sat_lat", lat, 34);
        do_ack("sat");

        // Max exponent difference
        exp_diff_i = 8'd255;
        run_op(0, lat, sh, ns, ov, zr, zc);
        chk("max_shifts", sh, 26);
        do_ack("max");

        // D=0, no carry, 5 normalization shifts
        exp_diff_i = 8'd0;
        carry_i = 1'b0;
        run_op(5, lat, sh, ns, ov, zr, zc);
        chk("norm5_shifts", ns, 5);
        chk("norm5_lat", lat, 14);
        chk("norm5_ovf", ov, 0);
        chk("norm5_align", sh, 0);
        do_ack("norm5");

        // D=4, no carry, msb already set: N=0
        exp_diff_i = 8'd4;
        run_op(0, lat, sh, ns, ov, zr, zc);
        chk("norm0_lat", lat, 13);
        chk("norm0_shifts", ns, 0);
        do_ack("norm0");

        // Equal-magnitude subtract
        exp_diff_i = 8'd0;
        carry_i = 1'b0;
        zero_flag_i = 1'b1;
        run_op(99, lat, sh, ns, ov, zr, zc);
`ifdef ZERO_BYPASS_EN
        chk("zero_lat", lat, 4);
        chk("zero_res_cnt", zr, 1);
        chk("zero_res_cyc", zc, 3);
        chk("zero_norm", ns, 0);
`else
        chk("zero_lat", lat, 35);
        chk("zero_norm", ns, 26);
        chk("zero_res_cnt", zr, 0);
`endif
        zero_flag_i = 1'b0;
        do_ack("zero");

        // beg held high, early ack in ADD ignored
        exp_diff_i = 8'd0;
        carry_i = 1'b1;
        beg_fsm_i = 1'b1;
        tick();
        tick(); tick(); tick();
        chk("hold_add", int'(add_en_o), 1);
        ack_fsm_i = 1'b1;
        tick();
        ack_fsm_i = 1'b0;
        chk("hold_ovf", int'(ovf_shift_o), 1);
        tick(); tick(); tick();
        chk("hold_ready", int'(ready_o), 1);
        tick();
        chk("hold_ready2", int'(ready_o), 1);
        ack_fsm_i = 1'b1;
        tick();
        ack_fsm_i = 1'b0;
        chk("hold_idle_busy", int'(busy_o), 0);
        chk("hold_idle_ready", int'(ready_o), 0);
        tick();
        beg_fsm_i = 1'b0;
        chk("hold_restart", int'(ctrl_a_o), 1);
        cyc = 1;
        while (!ready_o && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("hold_second_lat", cyc, 8);
        do_ack("hold");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
